// File: rtl/lane_packer.sv
// ============================================================================
// lane_packer : extracts the single live byte lane of each steered word and
// packs four bytes per output word. Option macro: LANE_PACKER_PARITY_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lane_packer #(
  parameter int WIDTH     = 32,
  parameter int DROP_ZERO = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_bytes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             multi_err,
`ifdef LANE_PACKER_PARITY_EN
  output logic [3:0]       out_parity,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic c_keep_zero = (DROP_ZERO == 0);

  logic [1:0]       cnt_q, cnt_d;
  logic [23:0]      pack_q, pack_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [2:0]       out_bytes_q, out_bytes_d;
  logic             out_valid_q, out_valid_d;
  logic             multi_err_q, multi_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef LANE_PACKER_PARITY_EN
  logic [3:0]       out_parity_q, out_parity_d;
`endif

  logic [3:0]  lane_nz;
  logic [7:0]  lane_byte;
  logic        is_multi;
  logic        out_free;
  logic        accept;
  logic        has_byte;
  logic        emit;
  logic [31:0] merged;
  logic [2:0]  byte_total;

  always_comb begin
    lane_nz = 4'd0;
    for (int i = 0; i < 4; i++) lane_nz[i] = |in_data[8*i +: 8];
  end

  // Lowest non-zero lane wins when the steering mux misbehaves.
  always_comb begin
    lane_byte = 8'h00;
    if (lane_nz[0])      lane_byte = in_data[7:0];
    else if (lane_nz[1]) lane_byte = in_data[15:8];
    else if (lane_nz[2]) lane_byte = in_data[23:16];
    else if (lane_nz[3]) lane_byte = in_data[31:24];
  end

  assign is_multi = (lane_nz & (lane_nz - 4'd1)) != 4'd0;
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = ((cnt_q != 2'd3) && !flush) || out_free;
  assign accept   = in_valid && in_ready;
  assign has_byte = accept && ((lane_nz != 4'd0) || c_keep_zero);

  always_comb begin
    merged = {8'h00, pack_q};
    if (has_byte) begin
      case (cnt_q)
        2'd0:    merged[7:0]   = lane_byte;
        2'd1:    merged[15:8]  = lane_byte;
        2'd2:    merged[23:16] = lane_byte;
        default: merged[31:24] = lane_byte;
      endcase
    end
  end

  assign byte_total = {1'b0, cnt_q} + {2'b00, has_byte};
  assign emit = (has_byte && (cnt_q == 2'd3)) ||
                (flush && out_free && ((cnt_q != 2'd0) || has_byte));

  always_comb begin
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_valid_d = out_valid_q;
    if (emit) begin
      cnt_d       = 2'd0;
      pack_d      = 24'd0;
      out_data_d  = merged;
      out_bytes_d = byte_total;
      out_valid_d = 1'b1;
    end else begin
      if (has_byte) begin
        cnt_d  = cnt_q + 2'd1;
        pack_d = merged[23:0];
      end
      if (out_ready) out_valid_d = 1'b0;
    end
  end

  always_comb begin
    multi_err_d = accept && is_multi;
    err_cnt_d   = err_cnt_q;
    if (multi_err_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

`ifdef LANE_PACKER_PARITY_EN
  always_comb begin
    out_parity_d = out_parity_q;
    if (emit) begin
      for (int i = 0; i < 4; i++) out_parity_d[i] = ^merged[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_parity_q <= 4'd0;
    else      out_parity_q <= out_parity_d;
  end

  assign out_parity = out_parity_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= 2'd0;
      pack_q      <= 24'd0;
      out_data_q  <= 32'd0;
      out_bytes_q <= 3'd0;
      out_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_valid_q <= out_valid_d;
      multi_err_q <= multi_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_valid = out_valid_q;
  assign multi_err = multi_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_packer.sv
// ============================================================================
// tb_lane_packer : scoreboard bench for lane_packer (both DROP_ZERO settings).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_lane_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        multi_err;
  logic [7:0]  err_cnt;

  logic [31:0] z_in_data = 32'd0;
  logic        z_in_valid = 1'b0;
  logic        z_in_ready;
  logic        z_flush = 1'b0;
  logic [31:0] z_out_data;
  logic [2:0]  z_out_bytes;
  logic        z_out_valid;
  logic        z_multi_err;
  logic [7:0]  z_err_cnt;
`ifdef LANE_PACKER_PARITY_EN
  logic [3:0]  out_parity;
  logic [3:0]  z_out_parity;
`endif

  always #5 clk = ~clk;

  lane_packer #(.WIDTH(32), .DROP_ZERO(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_bytes(out_bytes), .out_valid(out_valid),
    .out_ready(out_ready), .multi_err(multi_err),
`ifdef LANE_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .err_cnt(err_cnt)
  );

  lane_packer #(.WIDTH(32), .DROP_ZERO(0), .CNT_W(8)) dut_z (
    .clk(clk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .flush(z_flush), .out_data(z_out_data), .out_bytes(z_out_bytes), .out_valid(z_out_valid),
    .out_ready(1'b1), .multi_err(z_multi_err),
`ifdef LANE_PACKER_PARITY_EN
    .out_parity(z_out_parity),
`endif
    .err_cnt(z_err_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] b);
    exp_t e;
    e.d = d;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // Inputs change at posedge+1; in_ready is sampled at the preceding negedge.
  task automatic send(input logic [31:0] w);
    int   n;
    logic ok;
    in_data  = w;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0 expected accept of %h", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on handshake, checks held data across stalls.
  logic        held = 1'b0;
  logic [31:0] held_d;
  logic [2:0]  held_b;
  always @(negedge clk) begin
    if (rst) begin
      if (held && out_valid) begin
        chk("stall_data", out_data, held_d);
        chk("stall_bytes", {29'd0, out_bytes}, {29'd0, held_b});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %h/%0d expected none", out_data, out_bytes);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_bytes", {29'd0, out_bytes}, {29'd0, e.b});
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_b = out_bytes;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_bytes", {29'd0, out_bytes}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Four single-lane words, back to back
    push(32'hD4C3B2A1, 3'd4);
    send(32'h000000A1);
    send(32'h0000B200);
    send(32'h00C30000);
    chk("pre_emit_valid", {31'd0, out_valid}, 32'd0);
    send(32'hD4000000);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Partial word via flush, then flush with nothing pending
    push(32'h00002211, 3'd2);
    send(32'h00000011);
    send(32'h00002200);
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd1);
    tick();
    flush = 1'b0;
    chk("empty_flush_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // Multi-lane word, then counter saturation
    flush = 1'b1;
    push(32'h00000011, 3'd1);
    send(32'h00FF0011);
    flush = 1'b0;
    chk("multi_err_pulse", {31'd0, multi_err}, 32'd1);
    chk("err_cnt_one", {24'd0, err_cnt}, 32'd1);
    tick();
    chk("multi_err_clear", {31'd0, multi_err}, 32'd0);
    flush = 1'b1;
    for (int i = 0; i < 260; i++) begin
      push(32'h00000011, 3'd1);
      send(32'h00FF0011);
    end
    flush = 1'b0;
    tick();
    tick();
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'h000000FF);

    // All-zero words dropped
    push(32'h34333231, 3'd4);
    send(32'h00000031);
    send(32'h00000000);
    send(32'h00003200);
    send(32'h00000000);
    send(32'h00000000);
    send(32'h00330000);
    send(32'h34000000);
    tick();
    tick();

    // Backpressure: first word held, three bytes absorbed, eighth stalled
    out_ready = 1'b0;
    push(32'h04030201, 3'd4);
    push(32'h08070605, 3'd4);
    for (int i = 1; i <= 7; i++) send(32'(i) << (8 * ((i - 1) % 4)));
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    in_data  = 32'h08000000;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("second_word_valid", {31'd0, out_valid}, 32'd1);
    tick();
    tick();

    // DROP_ZERO=0 instance: zero byte is packed
    z_in_data  = 32'h00000000;
    z_in_valid = 1'b1;
    tick();
    z_in_data = 32'h000000AA;
    z_flush   = 1'b1;
    tick();
    z_in_valid = 1'b0;
    z_flush    = 1'b0;
    chk("z_valid", {31'd0, z_out_valid}, 32'd1);
    chk("z_data", z_out_data, 32'h0000AA00);
    chk("z_bytes", {29'd0, z_out_bytes}, 32'd2);
    tick();

    // Reset mid-word discards the partial bytes
    send(32'h000000E1);
    send(32'h0000E200);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_bytes", {29'd0, out_bytes}, 32'd0);
    chk("mid_rst_multi", {31'd0, multi_err}, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    push(32'hF4F3F2F1, 3'd4);
    send(32'h000000F1);
    send(32'h0000F200);
    send(32'h00F30000);
    send(32'hF4000000);
    repeat (4) tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
